// File: rtl/locked_reg_read_port.sv
// locked_reg_read_port
// Read-side access controller for a bank of lockable registers. A single
// read request is captured in IDLE. The lock and data of the target register
// are evaluated one edge later in CHECK, so a lock raised after capture still
// applies. A one-cycle ack is then issued, and the controller waits for the
// requester to drop rd_req. Denied reads update a saturating violation
// counter and a sticky flag.
module locked_reg_read_port #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4,
  parameter int VIOL_W   = 8
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         trusted,
  input  logic                         untrusted,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
  input  logic [NUM_REGS-1:0]          lock_status,
  input  logic                         viol_clear,
  output logic                         rd_ack,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_err,
  output logic [VIOL_W-1:0]            viol_count,
  output logic                         viol_sticky
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP, WAIT_DROP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                priv_q;
  logic                rd_ack_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_err_q;
  logic [VIOL_W-1:0]   viol_count_q, viol_count_d;
  logic                viol_sticky_q, viol_sticky_d;

  logic                sel_valid;
  logic                sel_lock;
  logic [DATA_W-1:0]   sel_data;
  logic                deny;
  logic                grant;

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [VIOL_W-1:0] sat_inc(input logic [VIOL_W-1:0] cnt);
    if (cnt == {VIOL_W{1'b1}}) begin
      return cnt;
    end
    return cnt + VIOL_W'(1);
  endfunction

  // Look up the captured address in the live bank; out-of-range stays invalid.
  always_comb begin
    sel_valid = 1'b0;
    sel_lock  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        sel_valid = 1'b1;
        sel_lock  = lock_status[i];
        sel_data  = reg_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Access decision is only meaningful in CHECK; invalid addresses are errors,
  // not violations.
  assign deny  = (state_q == CHECK) && sel_valid && sel_lock && !priv_q;
  assign grant = sel_valid && (!sel_lock || priv_q);

  // Next violation state: clear wins over history but not over a violation
  // landing in the same cycle.
  always_comb begin
    viol_count_d  = viol_count_q;
    viol_sticky_d = viol_sticky_q | deny;
    if (viol_clear) begin
      viol_count_d  = deny ? VIOL_W'(1) : '0;
      viol_sticky_d = deny;
    end else if (deny) begin
      viol_count_d  = sat_inc(viol_count_q);
    end
  end

  // Request handshake FSM with registered response outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      priv_q    <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            addr_q  <= rd_addr;
            priv_q  <= trusted & ~untrusted;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          rd_ack_q  <= 1'b1;
          rd_err_q  <= !grant;
          rd_data_q <= grant ? sel_data : '0;
          state_q   <= RESP;
        end
        RESP: begin
          rd_ack_q <= 1'b0;
          state_q  <= rd_req ? WAIT_DROP : IDLE;
        end
        WAIT_DROP: begin
          if (!rd_req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Violation counter and sticky flag registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      viol_count_q  <= '0;
      viol_sticky_q <= 1'b0;
    end else begin
      viol_count_q  <= viol_count_d;
      viol_sticky_q <= viol_sticky_d;
    end
  end

  assign rd_ack      = rd_ack_q;
  assign rd_data     = rd_data_q;
  assign rd_err      = rd_err_q;
  assign viol_count  = viol_count_q;
  assign viol_sticky = viol_sticky_q;

endmodule

// File: tb/tb_locked_reg_read_port.sv
// Directed bench for locked_reg_read_port. Two instances share every input:
// dut_a uses the default 8-bit violation counter and dut_b a 2-bit one for
// saturation.
module tb_locked_reg_read_port;

  logic          Clk;
  logic          reset;
  logic          rd_req;
  logic [3:0]    rd_addr;
  logic          trusted;
  logic          untrusted;
  logic [63:0]   reg_data;
  logic [3:0]    lock_status;
  logic          viol_clear;

  logic          rd_ack_a, rd_err_a, viol_sticky_a;
  logic [15:0]   rd_data_a;
  logic [7:0]    viol_count_a;
  logic          rd_ack_b, rd_err_b, viol_sticky_b;
  logic [15:0]   rd_data_b;
  logic [1:0]    viol_count_b;

  int n_tests = 0;
  int n_fail  = 0;

  locked_reg_read_port #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(4), .VIOL_W(8)) dut_a (
    .Clk(Clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .trusted(trusted), .untrusted(untrusted), .reg_data(reg_data),
    .lock_status(lock_status), .viol_clear(viol_clear),
    .rd_ack(rd_ack_a), .rd_data(rd_data_a), .rd_err(rd_err_a),
    .viol_count(viol_count_a), .viol_sticky(viol_sticky_a)
  );

  locked_reg_read_port #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(4), .VIOL_W(2)) dut_b (
    .Clk(Clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .trusted(trusted), .untrusted(untrusted), .reg_data(reg_data),
    .lock_status(lock_status), .viol_clear(viol_clear),
    .rd_ack(rd_ack_b), .rd_data(rd_data_b), .rd_err(rd_err_b),
    .viol_count(viol_count_b), .viol_sticky(viol_sticky_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One read transaction, launched at a falling edge. Checks ack latency,
  // response fields and violation state in the ack cycle, then the ack drop.
  // clr pulses viol_clear into the CHECK edge; late_lock is OR-ed into the
  // lock bits after the request has been captured.
  task automatic do_read(input string tag, input logic [3:0] a, input logic t,
                         input logic u, input logic [15:0] exp_d,
                         input logic exp_e, input logic [7:0] exp_cnt,
                         input logic exp_stk, input logic clr,
                         input logic [3:0] late_lock);
    int lat;
    lat = 0;
    rd_addr = a; trusted = t; untrusted = u; rd_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        viol_clear  = clr;
        lock_status = lock_status | late_lock;
      end else begin
        viol_clear = 1'b0;
      end
      if (rd_ack_a) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".lat"},    32'(lat),          32'd2);
    chk({tag, ".data"},   32'(rd_data_a),    32'(exp_d));
    chk({tag, ".err"},    32'(rd_err_a),     32'(exp_e));
    chk({tag, ".cnt"},    32'(viol_count_a), 32'(exp_cnt));
    chk({tag, ".sticky"}, 32'(viol_sticky_a), 32'(exp_stk));
    rd_req = 1'b0; viol_clear = 1'b0;
    @(negedge Clk);
    chk({tag, ".ackdrop"}, 32'(rd_ack_a), 32'd0);
  endtask

  int acks;

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; trusted = 1'b0; untrusted = 1'b0;
    reg_data = '0; lock_status = '0; viol_clear = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst.ack",    32'(rd_ack_a),      32'd0);
    chk("rst.data",   32'(rd_data_a),     32'd0);
    chk("rst.err",    32'(rd_err_a),      32'd0);
    chk("rst.cnt",    32'(viol_count_a),  32'd0);
    chk("rst.sticky", 32'(viol_sticky_a), 32'd0);
    reset = 1'b0;
    @(negedge Clk);

    reg_data[0*16 +: 16] = 16'hA5C3;
    reg_data[1*16 +: 16] = 16'h1234;
    reg_data[2*16 +: 16] = 16'hBEEF;
    reg_data[3*16 +: 16] = 16'h0F0F;

    // Unlocked read by untrusted requester
    do_read("unlock", 4'd2, 1'b0, 1'b1, 16'hBEEF, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000);

    // Locked register: untrusted denied, trusted granted
    lock_status = 4'b0010;
    do_read("lk_untr", 4'd1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd1, 1'b1, 1'b0, 4'b0000);
    chk("lk_untr.cntb", 32'(viol_count_b), 32'd1);
    do_read("lk_trus", 4'd1, 1'b1, 1'b0, 16'h1234, 1'b0, 8'd1, 1'b1, 1'b0, 4'b0000);
    repeat (3) @(negedge Clk);
    chk("hold.data", 32'(rd_data_a), 32'h1234);

    // Ambiguous privilege (both high, both low) is untrusted
    do_read("amb11", 4'd1, 1'b1, 1'b1, 16'h0000, 1'b1, 8'd2, 1'b1, 1'b0, 4'b0000);
    do_read("amb00", 4'd1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'd3, 1'b1, 1'b0, 4'b0000);
    chk("amb.cntb", 32'(viol_count_b), 32'd3);

    // Invalid address: error, no violation
    do_read("badaddr", 4'd9, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd3, 1'b1, 1'b0, 4'b0000);

    // Two more denials: 8-bit counter reaches 5, 2-bit counter saturates at 3
    do_read("sat1", 4'd1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd4, 1'b1, 1'b0, 4'b0000);
    do_read("sat2", 4'd1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd5, 1'b1, 1'b0, 4'b0000);
    chk("sat.cntb", 32'(viol_count_b), 32'd3);

    // Clear coincident with a violation leaves count=1, sticky=1
    do_read("clrviol", 4'd1, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd1, 1'b1, 1'b1, 4'b0000);
    chk("clrviol.cntb", 32'(viol_count_b), 32'd1);
    viol_clear = 1'b1;
    @(negedge Clk);
    viol_clear = 1'b0;
    chk("clr.cnt",    32'(viol_count_a),  32'd0);
    chk("clr.sticky", 32'(viol_sticky_a), 32'd0);

    // Lock raised after capture, before CHECK: denied
    lock_status = 4'b0000;
    do_read("latelock", 4'd3, 1'b0, 1'b1, 16'h0000, 1'b1, 8'd1, 1'b1, 1'b0, 4'b1000);
    lock_status = 4'b0000;

    // Held request produces a single ack; a re-raise gets a second one
    acks = 0;
    rd_addr = 4'd0; trusted = 1'b0; untrusted = 1'b1; rd_req = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      if (rd_ack_a) acks++;
    end
    rd_req = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if (rd_ack_a) acks++;
    end
    chk("hold10.acks", 32'(acks), 32'd1);
    chk("hold10.data", 32'(rd_data_a), 32'hA5C3);
    do_read("reraise", 4'd0, 1'b0, 1'b1, 16'hA5C3, 1'b0, 8'd1, 1'b1, 1'b0, 4'b0000);

    // Reset during CHECK aborts the read and clears outputs immediately
    rd_addr = 4'd2; rd_req = 1'b1;
    @(negedge Clk);
    reset = 1'b1;
    #1;
    chk("midrst.ack",    32'(rd_ack_a),      32'd0);
    chk("midrst.data",   32'(rd_data_a),     32'd0);
    chk("midrst.cnt",    32'(viol_count_a),  32'd0);
    chk("midrst.sticky", 32'(viol_sticky_a), 32'd0);
    @(negedge Clk);
    chk("midrst.noack", 32'(rd_ack_a), 32'd0);
    rd_req = 1'b0;
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    do_read("postrst", 4'd2, 1'b0, 1'b1, 16'hBEEF, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/locked_reg_read_port.md
# locked_reg_read_port

Read-side access controller for a bank of lockable 16-bit registers. It serves single-word read requests over a req/ack handshake. It returns register contents only when the target register is unlocked or the requester is trusted. It logs denied accesses in a saturating violation counter and a sticky flag. It sits between the bus-facing requester and the locked register bank, whose data and lock bits it observes.

## Interface
- DATA_W, 16, register width
- NUM_REGS, 4, registers in bank (2..16)
- ADDR_W, 4, read address width; addresses >= NUM_REGS are invalid
- VIOL_W, 8, violation counter width
- Clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rd_req  input  1  read request; held high until rd_ack seen
- rd_addr  input  ADDR_W  register index, valid while rd_req high
- trusted  input  1  requester privilege, sampled with request
- untrusted  input  1  requester non-privilege, sampled with request
- reg_data  input  NUM_REGS*DATA_W  flattened bank contents, reg i at [i*DATA_W +: DATA_W]
- lock_status  input  NUM_REGS  per-register lock bit, 1 = locked
- viol_clear  input  1  synchronous clear of viol_count and viol_sticky
- rd_ack  output  1  one-cycle response strobe
- rd_data  output  DATA_W  response data, valid with rd_ack
- rd_err  output  1  response error, valid with rd_ack
- viol_count  output  VIOL_W  saturating count of denied reads
- viol_sticky  output  1  set on any denied read, cleared only by viol_clear/reset

## Operation
- FSM states: IDLE, CHECK, RESP, WAIT_DROP.
- IDLE: on rd_req=1, latch rd_addr and the privilege decision, then go to CHECK.
- Privilege: effective_trusted = trusted & ~untrusted. Both high or both low means untrusted.
- CHECK: evaluate against lock_status and reg_data at this edge, not at capture. Register rd_data/rd_err, drive rd_ack=1, then go to RESP.
  - addr >= NUM_REGS: rd_err=1, rd_data=0. Not a violation.
  - locked and not effective_trusted: rd_err=1, rd_data=0. Violation.
  - otherwise: rd_err=0, rd_data=reg_data[addr].
- RESP: drop rd_ack. If rd_req=0, go to IDLE, else go to WAIT_DROP.
- WAIT_DROP: stay until rd_req=0, then go to IDLE. New requests are ignored until the FSM returns to IDLE.
- Violation: viol_count increments by 1 and saturates at 2^VIOL_W-1. viol_sticky is set.
- viol_clear: count goes to 0 and sticky to 0. If a violation occurs in the same cycle, the result is count=1 and sticky=1.
- rd_data/rd_err hold their last response value until the next CHECK. Never cleared by IDLE.

## Timing
- Reset (async assert): state=IDLE, rd_ack=0, rd_data=0, rd_err=0, viol_count=0, viol_sticky=0.
- Reset mid-transaction aborts it; no rd_ack is issued for the aborted request.
- Request sampled at edge N (IDLE). CHECK evaluates at edge N+1. rd_ack is high for exactly the cycle between edges N+1 and N+2.
- Latency: 2 edges from sampled request to ack.
- viol_count/viol_sticky update at edge N+1, coincident with rd_ack.
- Lock asserted between edge N and N+1 is honoured: the read is denied.
- Back-to-back throughput: minimum 3 cycles per access when the requester drops rd_req in the ack cycle.
- At most one rd_ack per rd_req high period.

## Test plan
- Unlocked read: lock_status=0000, reg_data[2]=16'hBEEF, rd_req with addr 2, untrusted=1 -> rd_ack 2 cycles later, rd_data=BEEF, rd_err=0, viol_count=0.
- Locked, untrusted: lock_status[1]=1, reg1=16'h1234, addr 1, trusted=0/untrusted=1 -> rd_err=1, rd_data=0, viol_count=1, viol_sticky=1. Repeat with trusted=1/untrusted=0 -> rd_data=1234, rd_err=0, count stays 1.
- Ambiguous privilege: trusted=1 and untrusted=1 on locked reg -> denied, count increments. Invalid addr 9 -> rd_err=1, count unchanged.
- Saturation/clear: VIOL_W=2, 5 denied reads -> viol_count=3. Pulse viol_clear coincident with a 6th violation -> count=1, sticky=1.
- Handshake: hold rd_req high for 10 cycles -> exactly one rd_ack. Drop rd_req, re-raise -> second ack. Lock asserted one cycle after request sampled -> read denied.
- Reset mid-op: assert reset during CHECK -> no rd_ack; all outputs 0 immediately; first request after release completes normally.
